// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and row/word helper for the direct-mapped instruction cache.
package icache_pkg;
  localparam int LINE_BYTES = 64;
  localparam int OFFSET_W   = 6;
  localparam int ROW_W      = LINE_BYTES * 8;
  localparam int BIT_W      = OFFSET_W + 3;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Little-endian 32-bit word at a byte offset; bits [1:0] of the offset are ignored.
  function automatic logic [31:0] row_word(input logic [ROW_W-1:0] row,
                                           input logic [OFFSET_W-1:0] off);
    logic [BIT_W-1:0] lo;
    lo = {off[OFFSET_W-1:2], 5'b00000};
    return row[lo +: 32];
  endfunction
endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage: combinational read, single synchronous write, valid bits cleared on rst.
module icache_line_array import icache_pkg::*; #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 32 - OFFSET_W - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [ROW_W-1:0]   rd_row,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [ROW_W-1:0]   wr_row
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [ROW_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_row   = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst)     valid_q <= '0;
    else if (we) valid_q[wr_idx] <= 1'b1;
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_row;
    end
  end
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache; one outstanding fetch, refills 64-byte lines from mem_ctrl.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counter ports.
module icache import icache_pkg::*; #(
  parameter int INDEX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  output logic             if_ready,
  input  logic             if_req,
  input  logic [31:0]      if_pc,
  output logic             if_out_valid,
  output logic [31:0]      if_out_inst,
  output logic [31:0]      if_out_pc,
  output logic             mem_req,
  output logic [31:0]      mem_pc,
  input  logic [ROW_W-1:0] mem_row,
  input  logic             mem_done
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);
  localparam int TAG_W = 32 - OFFSET_W - INDEX_W;

  state_e             state_q, state_d;
  logic [31:0]        pend_pc;
  logic               cancel;
  logic               lk_valid;
  logic [TAG_W-1:0]   lk_tag;
  logic [ROW_W-1:0]   lk_row;
  logic               accept, hit, miss, fill;

  assign if_ready = (state_q == IDLE);
  assign accept   = rdy && if_ready && if_req && !rollback;
  assign hit      = accept && lk_valid && (lk_tag == if_pc[31 -: TAG_W]);
  assign miss     = accept && !hit;
  assign fill     = rdy && (state_q == REFILL) && mem_done;

  icache_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[OFFSET_W +: INDEX_W]),
    .rd_valid (lk_valid),
    .rd_tag   (lk_tag),
    .rd_row   (lk_row),
    .we       (fill && !rst),
    .wr_idx   (pend_pc[OFFSET_W +: INDEX_W]),
    .wr_tag   (pend_pc[31 -: TAG_W]),
    .wr_row   (mem_row)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = REFILL;
      REFILL:  if (fill) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // mem_pc is only written on a miss, so it stays fixed for the whole burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_pc      <= '0;
      cancel       <= 1'b0;
      mem_req      <= 1'b0;
      mem_pc       <= '0;
      if_out_valid <= 1'b0;
      if_out_inst  <= '0;
      if_out_pc    <= '0;
    end else if (!rdy) begin
      if_out_valid <= 1'b0;
    end else begin
      if_out_valid <= 1'b0;
      if (hit) begin
        if_out_valid <= 1'b1;
        if_out_inst  <= row_word(lk_row, if_pc[OFFSET_W-1:0]);
        if_out_pc    <= if_pc;
      end
      if (miss) begin
        pend_pc <= if_pc;
        cancel  <= 1'b0;
        mem_req <= 1'b1;
        mem_pc  <= {if_pc[31:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      if (state_q == REFILL && rollback) cancel <= 1'b1;
      if (fill) begin
        mem_req <= 1'b0;
        if (!cancel && !rollback) begin
          if_out_valid <= 1'b1;
          if_out_inst  <= row_word(mem_row, pend_pc[OFFSET_W-1:0]);
          if_out_pc    <= pend_pc;
        end
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// Bench for icache: mem_ctrl responder, line-address cache model, per-cycle compare and directed/random fetches.
module tb_icache;
  localparam int INDEX_W = 4;
  localparam int LINES   = 1 << INDEX_W;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback, if_req, mem_done;
  logic [31:0]  if_pc;
  logic [511:0] mem_row;
  logic         if_ready, if_out_valid, mem_req;
  logic [31:0]  if_out_inst, if_out_pc, mem_pc;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_ready(if_ready), .if_req(if_req), .if_pc(if_pc),
    .if_out_valid(if_out_valid), .if_out_inst(if_out_inst), .if_out_pc(if_out_pc),
    .mem_req(mem_req), .mem_pc(mem_pc), .mem_row(mem_row), .mem_done(mem_done)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: line 0x1000 holds byte i = i, other lines are xor-scrambled.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [25:0] ln;
    ln = a[31:6] - 26'h40;
    return a[7:0] ^ 8'(ln * 26'd29);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  function automatic logic [511:0] make_row(input logic [31:0] base);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = mem_byte(base + 32'(i));
    return r;
  endfunction

  // mem_ctrl stand-in: pulses mem_done lat active cycles after mem_req rises.
  int lat = 5;
  int rcnt = 0;
  bit served = 0;
  initial begin
    mem_done = 1'b0;
    mem_row  = '0;
    forever begin
      @(negedge clk); #1;
      mem_done = 1'b0;
      if (rst) begin
        rcnt = 0; served = 0;
      end else if (mem_req && !served && rdy) begin
        rcnt++;
        if (rcnt >= lat) begin
          mem_done = 1'b1;
          mem_row  = make_row(mem_pc);
          served   = 1;
          rcnt     = 0;
        end
      end
      if (!mem_req) served = 0;
    end
  end

  // Model: per index, which line address is resident; one pending fetch.
  bit          m_valid [LINES];
  logic [25:0] m_line  [LINES];
  bit          m_busy = 0, m_cancel = 0;
  logic [31:0] m_pend = '0;
  logic        e_valid = 1'b0, e_req = 1'b0;
  logic [31:0] e_inst = '0, e_pc = '0, e_mempc = '0;
  int          m_hits = 0, m_misses = 0;
  int          midx;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < LINES; i++) m_valid[i] = 0;
      m_busy = 0; m_cancel = 0; e_valid = 0; e_req = 0;
      e_inst = '0; e_pc = '0; e_mempc = '0; m_hits = 0; m_misses = 0;
    end else if (!rdy) begin
      e_valid = 0;
    end else begin
      e_valid = 0;
      if (!m_busy) begin
        if (if_req && !rollback) begin
          midx = int'(if_pc[6 +: INDEX_W]);
          if (m_valid[midx] && m_line[midx] == if_pc[31:6]) begin
            e_valid = 1; e_inst = mem_word(if_pc); e_pc = if_pc; m_hits++;
          end else begin
            m_busy = 1; m_cancel = 0; m_pend = if_pc;
            e_req = 1; e_mempc = {if_pc[31:6], 6'b0}; m_misses++;
          end
        end
      end else begin
        if (rollback) m_cancel = 1;
        if (mem_done) begin
          midx = int'(m_pend[6 +: INDEX_W]);
          m_valid[midx] = 1; m_line[midx] = m_pend[31:6];
          m_busy = 0; e_req = 0;
          if (!m_cancel) begin
            e_valid = 1; e_inst = mem_word(m_pend); e_pc = m_pend;
          end
        end
      end
    end
  end

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("if_ready", 32'(if_ready), 32'(!m_busy));
      check("if_out_valid", 32'(if_out_valid), 32'(e_valid));
      if (e_valid) begin
        check("if_out_inst", if_out_inst, e_inst);
        check("if_out_pc", if_out_pc, e_pc);
      end
      check("mem_req", 32'(mem_req), 32'(e_req));
      if (e_req) check("mem_pc", mem_pc, e_mempc);
    end
  end

  // Response / burst log used by the literal checks.
  int          resp_cnt = 0, req_cnt = 0;
  logic [31:0] last_inst = '0, last_pc = '0, last_mempc = '0;
  logic        prev_req = 1'b0;
  initial forever begin
    @(negedge clk);
    if (if_out_valid === 1'b1) begin
      resp_cnt++; last_inst = if_out_inst; last_pc = if_out_pc;
    end
    if (mem_req === 1'b1 && !prev_req) begin
      req_cnt++; last_mempc = mem_pc;
    end
    prev_req = (mem_req === 1'b1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [31:0] pc);
    int n = 0;
    while (!(if_ready && rdy) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("fetch_timeout", 32'd1, 32'd0);
    if_req = 1'b1; if_pc = pc;
    @(negedge clk);
    if_req = 1'b0; if_pc = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || !if_ready) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h4000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 3) << 6) +
           ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
  endfunction

  int r0, q0, n;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_req = 1'b0; if_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_pc", mem_pc, 32'd0);
    check("rst_valid", 32'(if_out_valid), 32'd0);
    check("rst_inst", if_out_inst, 32'd0);
    check("rst_pc", if_out_pc, 32'd0);
    check("rst_ready", 32'(if_ready), 32'd1);
    rst = 1'b0; chk_en = 1;

    // cold miss, long refill
    lat = 70; fetch(32'h1004); wait_idle();
    check("cold_mem_pc", last_mempc, 32'h1000);
    check("cold_inst", last_inst, 32'h07060504);
    check("cold_pc", last_pc, 32'h1004);

    // hit in same line
    q0 = req_cnt; lat = 6;
    fetch(32'h103C); wait_idle();
    check("hit_inst", last_inst, 32'h3F3E3D3C);
    check("hit_no_req", 32'(req_cnt - q0), 32'd0);

    // conflict miss replaces the line, then original misses again
    fetch(32'h1404); wait_idle();
    check("conf_mem_pc", last_mempc, 32'h1400);
    check("conf_inst", last_inst, 32'hD7D6D5D4);
    q0 = req_cnt;
    fetch(32'h1004); wait_idle();
    check("refetch_miss", 32'(req_cnt - q0), 32'd1);
    check("refetch_inst", last_inst, 32'h07060504);

    // rollback mid-refill: line installed, no response
    lat = 30; r0 = resp_cnt;
    fetch(32'h2008);
    repeat (9) @(negedge clk);
    rollback = 1'b1; @(negedge clk); rollback = 1'b0;
    wait_idle();
    check("rb_no_resp", 32'(resp_cnt - r0), 32'd0);
    q0 = req_cnt;
    fetch(32'h2008); wait_idle();
    check("rb_then_hit", 32'(req_cnt - q0), 32'd0);
    check("rb_hit_inst", last_inst, 32'h4B4A4948);

    // rollback in IDLE swallows a simultaneous request
    r0 = resp_cnt; q0 = req_cnt;
    rollback = 1'b1; if_req = 1'b1; if_pc = 32'h3000;
    @(negedge clk); rollback = 1'b0; if_req = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_rb_req", 32'(req_cnt - q0), 32'd0);
    check("idle_rb_resp", 32'(resp_cnt - r0), 32'd0);

    // rdy low around mem_done, then around a hit
    lat = 20; r0 = resp_cnt;
    fetch(32'h3010);
    repeat (18) @(negedge clk);
    rdy = 1'b0; repeat (5) @(negedge clk); rdy = 1'b1;
    wait_idle();
    check("rdy_fill_resp", 32'(resp_cnt - r0), 32'd1);
    check("rdy_fill_inst", last_inst, 32'h93929190);
    r0 = resp_cnt;
    fetch(32'h3010);
    rdy = 1'b0; repeat (5) @(negedge clk); rdy = 1'b1;
    wait_idle();
    check("rdy_hit_resp", 32'(resp_cnt - r0), 32'd1);
    r0 = resp_cnt;
    rdy = 1'b0; if_req = 1'b1; if_pc = 32'h3014;
    repeat (2) @(negedge clk);
    if_req = 1'b0; rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rdy_low_req", 32'(resp_cnt - r0), 32'd0);

    // reset mid-refill abandons it and invalidates everything
    lat = 500;
    fetch(32'h5000);
    repeat (10) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 32'd0);
    rst = 1'b0; lat = 5;
    q0 = req_cnt;
    fetch(32'h1004); wait_idle();
    fetch(32'h2008); wait_idle();
    check("post_rst_miss", 32'(req_cnt - q0), 32'd2);
    check("post_rst_inst", last_inst, 32'h4B4A4948);

    // random traffic with rollback, rdy stalls and stray requests during refills
    for (int it = 0; it < 300; it++) begin
      lat = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) begin
        rollback = 1'b1; if_req = 1'b1; if_pc = rand_pc();
        @(negedge clk); rollback = 1'b0; if_req = 1'b0;
      end
      fetch(rand_pc());
      n = 0;
      while (m_busy && n < 500) begin
        rdy      = ($urandom_range(0, 7) != 0);
        rollback = ($urandom_range(0, 19) == 0);
        if_req   = ($urandom_range(0, 3) == 0);
        if_pc    = $urandom;
        @(negedge clk); n++;
      end
      if (n >= 500) check("rand_timeout", 32'd1, 32'd0);
      rdy = 1'b1; rollback = 1'b0; if_req = 1'b0;
      @(negedge clk);
    end
    wait_idle();
`ifdef ICACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'(m_hits));
    check("miss_cnt", miss_cnt, 32'(m_misses));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction fetch stage and `mem_ctrl`. It serves 32-bit instruction reads from 64-byte lines. On a miss it acts as the initiator of the `mem_ctrl` instruction-line protocol: it drives `inst_config`/`inst_PC` and consumes `inst_row`/`inst_out_config`. One fetch request is outstanding at a time, and a ROB rollback cancels it.

## Interface
- `INDEX_W`, default 4: index bits; the cache has 2^INDEX_W lines of 64 bytes. Tag is `pc[31:6+INDEX_W]`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rdy`  in  1  global enable; low freezes the block
- `rollback`  in  1  ROB rollback; cancels the pending fetch
- `if_ready`  out  1  combinational; high when in IDLE, i.e. able to accept `if_req`
- `if_req`  in  1  fetch request; sampled only when `if_ready`
- `if_pc`  in  32  fetch address; bits [1:0] are ignored
- `if_out_valid`  out  1  one-cycle pulse; response valid
- `if_out_inst`  out  32  instruction word
- `if_out_pc`  out  32  PC of the returned instruction
- `mem_req`  out  1  to `mem_ctrl.inst_config`
- `mem_pc`  out  32  to `mem_ctrl.inst_PC`; always `{line[31:6], 6'b0}`
- `mem_row`  in  512  from `mem_ctrl.inst_row`; byte i is `[i*8+7:i*8]`
- `mem_done`  in  1  from `mem_ctrl.inst_out_config`; one-cycle pulse, `mem_row` valid in that cycle

## Operation
- State machine: IDLE and REFILL.
- IDLE, `if_req` high, `rollback` low:
  - Lookup at `index = if_pc[5+INDEX_W:6]`.
  - Hit (valid bit set and tag match): register `if_out_inst` = line bytes `[off+3:off]` (little-endian, `off = {if_pc[5:2],2'b00}`), set `if_out_pc = if_pc`, pulse `if_out_valid`. Stay in IDLE.
  - Miss: latch `if_pc` as `pend_pc`, set `mem_req=1` and `mem_pc={if_pc[31:6],6'b0}`, clear `cancel`, go to REFILL.
- REFILL:
  - `mem_req` and `mem_pc` are held constant until `mem_done` is sampled. `mem_ctrl` compares `inst_PC` during the burst, so `mem_pc` must never change mid-refill.
  - On `mem_done`: write `mem_row` into the data array, write the tag, set the valid bit. Drop `mem_req` at the same edge and return to IDLE.
  - In the same `mem_done` cycle, if `cancel` is clear and `rollback` is low, register the response from `mem_row` at the `pend_pc` offset and pulse `if_out_valid`.
- Rollback:
  - In IDLE, a simultaneous `if_req` is ignored.
  - In REFILL, set `cancel`. The refill still completes and the line is still installed, but no response is produced.
  - Rollback never aborts the `mem_ctrl` handshake.
- The block never issues two `mem_req` bursts back to back without at least one cycle with `mem_req` low.
- `rdy` low: state, arrays and `mem_req`/`mem_pc` hold. `if_out_valid` is forced to 0. `mem_done` cannot occur while `rdy` is low (`mem_ctrl` suppresses it).
- Reset:
  - All valid bits 0.
  - State IDLE.
  - `mem_req=0`, `mem_pc=0`, `if_out_valid=0`, `if_out_inst=0`, `if_out_pc=0`, `cancel=0`.
  - Reset during REFILL abandons the refill. `mem_ctrl` is reset by the same `rst`.

## Timing
- Hit: `if_req` sampled at edge t; `if_out_valid` high in cycle t+1.
- Miss: `mem_req` high from cycle t+1. If `mem_done` is sampled at edge d, `if_out_valid` and `mem_req=0` both take effect in cycle d+1, and `if_ready` is high in cycle d+1.
- `if_out_valid` lasts exactly one cycle.
- The fetch stage must not change `if_pc` meaning after issue. `if_pc` is not re-sampled during REFILL.

## Configuration
- `ICACHE_STATS_EN` defined: adds output ports `hit_cnt` (32) and `miss_cnt` (32).
  - Both reset to 0.
  - Each increments once per accepted, non-rollback `if_req`, as hit or miss respectively.
  - Both wrap at 2^32.
  - Both are frozen while `rdy` is low.
- `ICACHE_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds: `LINE_BYTES=64`, `OFFSET_W=6`, state encoding (IDLE, REFILL), and a function that extracts a word from a 512-bit row at a given offset.
- One sub-module, `icache_line_array`:
  - Tag, valid and data storage for 2^INDEX_W lines.
  - Combinational read port.
  - Single synchronous write port.
  - Synchronous valid clear on `rst`.

## Test plan
- Cold miss at `if_pc=0x1004`; bench drives `mem_done` 70 cycles later with byte i = i, so the word at offset 4 is `0x07060504` -> `mem_pc=0x1000` held for the whole burst; `if_out_inst=0x07060504` and `if_out_pc=0x1004` one cycle after `mem_done`.
- Follow-up `if_pc=0x103C` -> hit, `if_out_inst=0x3F3E3D3C` on the next cycle, `mem_req` stays 0.
- `if_pc=0x1000+(1<<(6+INDEX_W))` (same index, different tag) -> miss, the line is replaced; then `0x1004` misses again.
- Rollback 10 cycles into a refill -> `mem_req` held until `mem_done`, no `if_out_valid`; a later fetch of the same line hits.
- `rdy` low for 5 cycles around `mem_done` and around a hit -> no lost or duplicated response, `mem_pc` unchanged.
- `rst` asserted mid-REFILL -> next cycle `mem_req=0`; all previously filled lines miss.
